// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Provides the FSM state type, instruction size and PC alignment mask.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      HOLD
   } fetch_state_t;

   localparam int INSTR_BYTES = 4;

   // Wide enough for any DATA_WIDTH up to 64; users slice the low bits.
   localparam logic [63:0] ALIGN_MASK = ~64'(INSTR_BYTES - 1);

endpackage

// File: rtl/pc_next.sv
// Combinational next-fetch-PC select: sequential PC+4 or aligned
// redirect target. Ports: fetch_pc, branch_pc, imm_op, redirect -> next_pc.
module pc_next
   import fetch_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] fetch_pc,
   input  logic [DATA_WIDTH-1:0] branch_pc,
   input  logic [DATA_WIDTH-1:0] imm_op,
   input  logic                  redirect,
   output logic [DATA_WIDTH-1:0] next_pc
);

   logic [DATA_WIDTH-1:0] seq_pc;
   logic [DATA_WIDTH-1:0] target;

   // Both sums wrap modulo 2^DATA_WIDTH.
   assign seq_pc = fetch_pc + DATA_WIDTH'(INSTR_BYTES);
   assign target = (branch_pc + imm_op)
                 & ALIGN_MASK[DATA_WIDTH-1:0];

   assign next_pc = redirect ? target : seq_pc;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the fetch PC, runs a one-outstanding imem
// handshake and presents instr/PC to decode with valid/stall.
// Ports: clk, rst, en, stall, PCsrc/branch_pc/ImmOp (redirect),
// imem_req/imem_addr/imem_ready/imem_rvalid/imem_rdata, instr_valid/instr/PC.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  stall,
   input  logic                  PCsrc,
   input  logic [DATA_WIDTH-1:0] branch_pc,
   input  logic [DATA_WIDTH-1:0] ImmOp,
   output logic                  imem_req,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic                  imem_ready,
   input  logic                  imem_rvalid,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic                  instr_valid,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [DATA_WIDTH-1:0] PC
);

   fetch_state_t          state;
   logic [DATA_WIDTH-1:0] fetch_pc;
   logic [DATA_WIDTH-1:0] next_pc;
   // Set when an in-flight response must be dropped.
   logic                  squash;

   pc_next #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_pc_next (
      .fetch_pc (fetch_pc),
      .branch_pc(branch_pc),
      .imm_op   (ImmOp),
      .redirect (PCsrc),
      .next_pc  (next_pc)
   );

   assign imem_req  = (state == REQ);
   assign imem_addr = fetch_pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         fetch_pc    <= RESET_PC;
         squash      <= 1'b0;
         instr_valid <= 1'b0;
         instr       <= '0;
         PC          <= RESET_PC;
      end else if (PCsrc) begin
         fetch_pc    <= next_pc;
         instr_valid <= 1'b0;
         unique case (state)
            IDLE, HOLD: state <= en ? REQ : IDLE;
            REQ: begin
               if (imem_ready) begin
                  state  <= WAIT;
                  squash <= 1'b1;
               end
            end
            WAIT: begin
               if (imem_rvalid) begin
                  state  <= REQ;
                  squash <= 1'b0;
               end else begin
                  squash <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end else begin
         unique case (state)
            IDLE: if (en) state <= REQ;
            REQ:  if (imem_ready) state <= WAIT;
            WAIT: begin
               if (imem_rvalid) begin
                  if (squash) begin
                     squash <= 1'b0;
                     state  <= REQ;
                  end else begin
                     instr       <= imem_rdata;
                     PC          <= fetch_pc;
                     instr_valid <= 1'b1;
                     fetch_pc    <= next_pc;
                     state       <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (!stall) begin
                  instr_valid <= 1'b0;
                  state       <= en ? REQ : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed scenarios plus a randomized
// run checked against a transaction-level fetch model.
module tb_fetch_sequencer;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         en;
   logic         stall;
   logic         PCsrc;
   logic [W-1:0] branch_pc;
   logic [W-1:0] ImmOp;
   logic         imem_req;
   logic [W-1:0] imem_addr;
   logic         imem_ready;
   logic         imem_rvalid;
   logic [W-1:0] imem_rdata;
   logic         instr_valid;
   logic [W-1:0] instr;
   logic [W-1:0] PC;

   always #5 clk = ~clk;

   fetch_sequencer #(
      .DATA_WIDTH(W),
      .RESET_PC  ('0)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .stall      (stall),
      .PCsrc      (PCsrc),
      .branch_pc  (branch_pc),
      .ImmOp      (ImmOp),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rvalid(imem_rvalid),
      .imem_rdata (imem_rdata),
      .instr_valid(instr_valid),
      .instr      (instr),
      .PC         (PC)
   );

   int pass_cnt = 0;
   int total    = 0;

   // memory emulation knobs/state
   logic         rdy;
   int           dly;
   logic [W-1:0] salt;
   logic         pend;
   int           cnt;
   logic [W-1:0] pend_addr;
   logic [W-1:0] acc_q[$];

   // random-phase model state
   logic [W-1:0] exp_next;
   logic [W-1:0] last_acc;
   logic         live;
   logic         shown;

   function automatic logic [W-1:0] mdata(logic [W-1:0] a);
      return salt ^ (32'hA0 + (a >> 2));
   endfunction

   task automatic chk(string tag, logic [W-1:0] obs,
                      logic [W-1:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: got %h want %h", tag, obs, exp);
   endtask

   // One clock cycle: drive memory, take the edge, record acceptance.
   task automatic cycle();
      logic         acc;
      logic [W-1:0] acc_a;
      logic         rv;
      imem_ready = rdy;
      if (pend && cnt == 0) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mdata(pend_addr);
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
         if (pend) cnt--;
      end
      acc   = imem_req && imem_ready;
      acc_a = imem_addr;
      rv    = imem_rvalid;
      @(posedge clk);
      if (rv) pend = 1'b0;
      if (acc && !rst) begin
         pend      = 1'b1;
         cnt       = dly - 1;
         pend_addr = acc_a;
         acc_q.push_back(acc_a);
      end
      #1;
   endtask

   task automatic wait_valid(string tag, output int n);
      n = 0;
      while (!instr_valid && n < 50) begin
         cycle();
         n++;
      end
      total++;
      assert (instr_valid === 1'b1) pass_cnt++;
      else $error("FAIL %s: instr_valid timeout got %b want 1",
                  tag, instr_valid);
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      en    = 1'b0;
      stall = 1'b0;
      PCsrc = 1'b0;
      rdy   = 1'b0;
      cycle();
      cycle();
      rst = 1'b0;
   endtask

   // One randomized step with model checking.
   task automatic rnd_step();
      logic         pc;
      logic         was_valid;
      logic         will_acc;
      logic [W-1:0] a;
      rdy = 1'($urandom_range(0, 1));
      dly = $urandom_range(1, 3);
      if (instr_valid && !shown) begin
         chk("rnd_live", {31'd0, live}, 1);
         chk("rnd_pc", PC, last_acc);
         chk("rnd_instr", instr, mdata(last_acc));
         shown = 1'b1;
         live  = 1'b0;
      end
      if (instr_valid)
         chk("rnd_noreq", {31'd0, imem_req}, 0);
      pc    = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 99) < 40);
      PCsrc = pc;
      branch_pc = $urandom;
      ImmOp     = $urandom;
      was_valid = instr_valid;
      will_acc  = imem_req && rdy;
      a         = imem_addr;
      if (will_acc) chk("rnd_addr", a, exp_next);
      cycle();
      if (will_acc) begin
         live     = 1'b1;
         last_acc = a;
      end
      if (pc) begin
         exp_next = (branch_pc + ImmOp) & ~32'd3;
         live     = 1'b0;
         shown    = 1'b0;
      end else if (was_valid && !stall) begin
         exp_next = last_acc + 4;
         shown    = 1'b0;
      end
      PCsrc = 1'b0;
   endtask

   initial begin
      int n;
      int n1;
      rst         = 1'b1;
      en          = 1'b0;
      stall       = 1'b0;
      PCsrc       = 1'b0;
      branch_pc   = '0;
      ImmOp       = '0;
      imem_ready  = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      rdy         = 1'b0;
      dly         = 1;
      salt        = '0;
      pend        = 1'b0;
      cnt         = 0;
      pend_addr   = '0;

      // reset state
      do_reset();
      chk("rst_req", {31'd0, imem_req}, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_valid", {31'd0, instr_valid}, 0);
      chk("rst_instr", instr, 0);
      chk("rst_pc", PC, 0);

      // 1: two sequential fetches
      en  = 1'b1;
      rdy = 1'b1;
      dly = 1;
      acc_q.delete();
      wait_valid("t1a", n);
      chk("t1_pc0", PC, 32'h0);
      chk("t1_in0", instr, 32'hA0);
      cycle();
      wait_valid("t1b", n1);
      chk("t1_pc4", PC, 32'h4);
      chk("t1_in1", instr, 32'hA1);
      chk("t1_rate", n1 + 1, 3);
      chk("t1_nacc", acc_q.size(), 2);
      if (acc_q.size() == 2) begin
         chk("t1_addr0", acc_q[0], 32'h0);
         chk("t1_addr1", acc_q[1], 32'h4);
      end

      // 2: stall hold at PC=8
      cycle();
      wait_valid("t2", n);
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("t2_valid", {31'd0, instr_valid}, 1);
         chk("t2_pc", PC, 32'h8);
         chk("t2_instr", instr, 32'hA2);
         chk("t2_noreq", {31'd0, imem_req}, 0);
      end
      stall = 1'b0;
      cycle();
      chk("t2_req", {31'd0, imem_req}, 1);
      chk("t2_addr", imem_addr, 32'hC);
      wait_valid("t2b", n);
      chk("t2_pcC", PC, 32'hC);

      // 3: redirect while waiting on 0x10
      acc_q.delete();
      dly = 3;
      cycle();
      cycle();
      PCsrc     = 1'b1;
      branch_pc = 32'h0C;
      ImmOp     = 32'h20;
      cycle();
      PCsrc = 1'b0;
      dly   = 1;
      wait_valid("t3", n);
      chk("t3_pc", PC, 32'h2C);
      chk("t3_instr", instr, mdata(32'h2C));
      chk("t3_nacc", acc_q.size(), 2);
      if (acc_q.size() == 2) begin
         chk("t3_addr0", acc_q[0], 32'h10);
         chk("t3_addr1", acc_q[1], 32'h2C);
      end

      // 4: REQ held with ready low, then redirect
      rdy = 1'b0;
      cycle();
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("t4_req", {31'd0, imem_req}, 1);
         chk("t4_addr", imem_addr, 32'h30);
      end
      PCsrc     = 1'b1;
      branch_pc = 32'h40;
      ImmOp     = 32'hFFFF_FFF8;
      cycle();
      PCsrc = 1'b0;
      chk("t4_req2", {31'd0, imem_req}, 1);
      chk("t4_addr2", imem_addr, 32'h38);
      rdy = 1'b1;
      wait_valid("t4", n);
      chk("t4_pc", PC, 32'h38);

      // 5: wrap past the top of the address space
      stall     = 1'b1;
      PCsrc     = 1'b1;
      branch_pc = 32'hFFFF_FFF0;
      ImmOp     = 32'hC;
      cycle();
      PCsrc = 1'b0;
      stall = 1'b0;
      wait_valid("t5", n);
      chk("t5_pc", PC, 32'hFFFF_FFFC);
      chk("t5_instr", instr, mdata(32'hFFFF_FFFC));
      cycle();
      chk("t5_req", {31'd0, imem_req}, 1);
      chk("t5_addr", imem_addr, 32'h0);
      wait_valid("t5b", n);
      chk("t5_pc0", PC, 32'h0);

      // 6: reset while waiting; late response ignored
      dly = 2;
      cycle();
      cycle();
      rst = 1'b1;
      rdy = 1'b0;
      en  = 1'b0;
      cycle();
      rst = 1'b0;
      chk("t6_pc", PC, 32'h0);
      chk("t6_instr", instr, 32'h0);
      cycle();
      chk("t6_valid", {31'd0, instr_valid}, 0);
      chk("t6_req", {31'd0, imem_req}, 0);
      chk("t6_addr", imem_addr, 32'h0);
      cycle();
      chk("t6_valid2", {31'd0, instr_valid}, 0);
      chk("t6_pc2", PC, 32'h0);

      // randomized run against the fetch model
      do_reset();
      pend     = 1'b0;
      salt     = $urandom;
      en       = 1'b1;
      exp_next = '0;
      last_acc = '0;
      live     = 1'b0;
      shown    = 1'b0;
      for (int i = 0; i < 600; i++) rnd_step();

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
